pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Generic in-order pipeline controller: per-stage valid/allow handshake, kill,
// operand forwarding with load-use hazard detection, and an occupancy counter.
module pipe_ctrl #(
  parameter int unsigned STAGES = 4,
  parameter int unsigned DW     = 64,
  parameter int unsigned AW     = 5,
  parameter int unsigned VW     = 32
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          in_valid,
  output logic                          in_allow,
  input  logic [DW-1:0]                 in_data,
  input  logic [AW-1:0]                 in_dest,
  input  logic                          in_wen,
  input  logic [STAGES-1:0]             ready_go,
  input  logic [STAGES-1:0]             kill,
  input  logic [STAGES*VW-1:0]          stage_val,
  input  logic [STAGES-1:0]             stage_val_ok,
  output logic                          out_valid,
  input  logic                          out_allow,
  output logic [DW-1:0]                 out_data,
  output logic [STAGES-1:0]             stage_valid,
  output logic [STAGES*DW-1:0]          stage_data,
  input  logic [AW-1:0]                 src1,
  input  logic [AW-1:0]                 src2,
  input  logic [1:0]                    src_re,
  output logic [1:0]                    fwd_hit,
  output logic [2*VW-1:0]               fwd_data,
  output logic                          hazard_stall,
  output logic [$clog2(STAGES+1)-1:0]   occ
);

  localparam int unsigned OW = $clog2(STAGES + 1);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] wen_q, wen_d;
  logic [DW-1:0]     data_q [STAGES];
  logic [DW-1:0]     data_d [STAGES];
  logic [AW-1:0]     dest_q [STAGES];
  logic [AW-1:0]     dest_d [STAGES];
  logic [OW-1:0]     occ_q, occ_d;

  logic [STAGES:0]   allow;
  logic [STAGES-1:0] pass;
  logic [STAGES-1:0] feed;
  logic [DW-1:0]     feed_data [STAGES];
  logic [AW-1:0]     feed_dest [STAGES];
  logic [STAGES-1:0] feed_wen;

  // allow ripples from the oldest stage back to the youngest
  always_comb begin
    allow         = '0;
    allow[STAGES] = out_allow;
    for (int unsigned i = 0; i < STAGES; i++) begin
      allow[STAGES-1-i] = !valid_q[STAGES-1-i] ||
                          (ready_go[STAGES-1-i] && allow[STAGES-i]);
    end
  end

  assign pass = valid_q & ready_go & ~kill;
  assign feed = {pass[STAGES-2:0], in_valid};

  always_comb begin
    feed_data[0] = in_data;
    feed_dest[0] = in_dest;
    feed_wen[0]  = in_wen;
    for (int unsigned s = 1; s < STAGES; s++) begin
      feed_data[s] = data_q[s-1];
      feed_dest[s] = dest_q[s-1];
      feed_wen[s]  = wen_q[s-1];
    end
  end

  always_comb begin
    valid_d = valid_q;
    wen_d   = wen_q;
    data_d  = data_q;
    dest_d  = dest_q;
    occ_d   = '0;
    for (int unsigned s = 0; s < STAGES; s++) begin
      // a blocked stage still drops its entry when killed
      if (allow[s]) begin
        valid_d[s] = feed[s];
      end else if (kill[s]) begin
        valid_d[s] = 1'b0;
      end
      if (allow[s] && feed[s]) begin
        data_d[s] = feed_data[s];
        dest_d[s] = feed_dest[s];
        wen_d[s]  = feed_wen[s];
      end
    end
    for (int unsigned s = 0; s < STAGES; s++) begin
      occ_d = occ_d + OW'(valid_d[s]);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      wen_q   <= '0;
      occ_q   <= '0;
      for (int unsigned s = 0; s < STAGES; s++) begin
        data_q[s] <= '0;
        dest_q[s] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      wen_q   <= wen_d;
      occ_q   <= occ_d;
      data_q  <= data_d;
      dest_q  <= dest_d;
    end
  end

  assign in_allow    = allow[0];
  assign out_valid   = pass[STAGES-1];
  assign out_data    = data_q[STAGES-1];
  assign stage_valid = valid_q;
  assign occ         = occ_q;

  for (genvar s = 0; s < STAGES; s++) begin : g_flat
    assign stage_data[s*DW +: DW] = data_q[s];
  end

  logic [AW-1:0] src   [2];
  logic [VW-1:0] fwd   [2];
  logic [1:0]    hit, stall, found;

  assign src[0] = src1;
  assign src[1] = src2;

  // youngest matching stage wins; a non-final value there stalls the source
  always_comb begin
    hit    = '0;
    stall  = '0;
    found  = '0;
    fwd[0] = '0;
    fwd[1] = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        if (!found[i] && src_re[i] && (src[i] != '0) && valid_q[s] && wen_q[s] &&
            (dest_q[s] == src[i]) && !kill[s]) begin
          found[i] = 1'b1;
          if (stage_val_ok[s]) begin
            hit[i] = 1'b1;
            fwd[i] = stage_val[s*VW +: VW];
          end else begin
            stall[i] = 1'b1;
          end
        end
      end
    end
  end

  assign fwd_hit      = hit;
  assign fwd_data     = {fwd[1], fwd[0]};
  assign hazard_stall = |stall;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (STAGES=4): vector table for streaming and
// backpressure, plus hand sequences for forwarding, kill and async reset.
module tb_pipe_ctrl;
  localparam int unsigned STAGES = 4;
  localparam int unsigned DW     = 64;
  localparam int unsigned AW     = 5;
  localparam int unsigned VW     = 32;
  localparam int unsigned OW     = 3;
  localparam int unsigned NV     = 25;

  logic                 clk = 1'b0;
  logic                 resetn;
  logic                 in_valid, in_allow, in_wen;
  logic [DW-1:0]        in_data;
  logic [AW-1:0]        in_dest;
  logic [STAGES-1:0]    ready_go, kill, stage_val_ok, stage_valid;
  logic [STAGES*VW-1:0] stage_val;
  logic                 out_valid, out_allow;
  logic [DW-1:0]        out_data;
  logic [STAGES*DW-1:0] stage_data;
  logic [AW-1:0]        src1, src2;
  logic [1:0]           src_re, fwd_hit;
  logic [2*VW-1:0]      fwd_data;
  logic                 hazard_stall;
  logic [OW-1:0]        occ;

  pipe_ctrl #(.STAGES(STAGES), .DW(DW), .AW(AW), .VW(VW)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_allow(in_allow),
    .in_data(in_data), .in_dest(in_dest), .in_wen(in_wen), .ready_go(ready_go),
    .kill(kill), .stage_val(stage_val), .stage_val_ok(stage_val_ok),
    .out_valid(out_valid), .out_allow(out_allow), .out_data(out_data),
    .stage_valid(stage_valid), .stage_data(stage_data), .src1(src1), .src2(src2),
    .src_re(src_re), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .hazard_stall(hazard_stall), .occ(occ)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pay(input logic [7:0] tag);
    return {48'hC0FF_EE00_1234, 8'h00, tag};
  endfunction

  typedef struct {
    logic       iv;
    logic [7:0] tag;
    logic       oa;
    logic       e_ia;
    logic       e_ov;
    logic [7:0] e_tag;
    logic [3:0] e_sv;
    logic [2:0] e_occ;
  } vec_t;

  vec_t tbl [NV];

  task automatic fwd_chk(input string name, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [1:0] re, input logic [3:0] ok, input logic [3:0] kl,
                         input logic [1:0] e_hit, input logic [31:0] e_lo,
                         input logic [31:0] e_hi, input logic e_haz);
    @(negedge clk);
    src1 = s1; src2 = s2; src_re = re; stage_val_ok = ok; kill = kl;
    #1;
    chk({name, "_hit"}, fwd_hit, e_hit);
    chk({name, "_lo"}, fwd_data[31:0], e_lo);
    chk({name, "_hi"}, fwd_data[63:32], e_hi);
    chk({name, "_haz"}, hazard_stall, e_haz);
    kill = '0;
  endtask

  task automatic push(input logic [7:0] tag, input logic [4:0] dest, input logic wen);
    @(negedge clk);
    in_valid = 1'b1; in_data = pay(tag); in_dest = dest; in_wen = wen;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 8'd0,  1'b1, 1'b1, 1'b0, 8'd0,  4'b0000, 3'd0};
    tbl[1]  = '{1'b1, 8'd1,  1'b1, 1'b1, 1'b0, 8'd0,  4'b0001, 3'd1};
    tbl[2]  = '{1'b1, 8'd2,  1'b1, 1'b1, 1'b0, 8'd0,  4'b0011, 3'd2};
    tbl[3]  = '{1'b1, 8'd3,  1'b1, 1'b1, 1'b0, 8'd0,  4'b0111, 3'd3};
    tbl[4]  = '{1'b1, 8'd4,  1'b1, 1'b1, 1'b1, 8'd0,  4'b1111, 3'd4};
    tbl[5]  = '{1'b1, 8'd5,  1'b1, 1'b1, 1'b1, 8'd1,  4'b1111, 3'd4};
    tbl[6]  = '{1'b1, 8'd6,  1'b1, 1'b1, 1'b1, 8'd2,  4'b1111, 3'd4};
    tbl[7]  = '{1'b1, 8'd7,  1'b1, 1'b1, 1'b1, 8'd3,  4'b1111, 3'd4};
    tbl[8]  = '{1'b0, 8'd0,  1'b1, 1'b1, 1'b1, 8'd4,  4'b1111, 3'd4};
    tbl[9]  = '{1'b0, 8'd0,  1'b1, 1'b1, 1'b1, 8'd5,  4'b1110, 3'd3};
    tbl[10] = '{1'b0, 8'd0,  1'b1, 1'b1, 1'b1, 8'd6,  4'b1100, 3'd2};
    tbl[11] = '{1'b0, 8'd0,  1'b1, 1'b1, 1'b1, 8'd7,  4'b1000, 3'd1};
    tbl[12] = '{1'b0, 8'd0,  1'b1, 1'b1, 1'b0, 8'd0,  4'b0000, 3'd0};
    tbl[13] = '{1'b1, 8'd8,  1'b0, 1'b1, 1'b0, 8'd0,  4'b0000, 3'd0};
    tbl[14] = '{1'b1, 8'd9,  1'b0, 1'b1, 1'b0, 8'd0,  4'b0001, 3'd1};
    tbl[15] = '{1'b1, 8'd10, 1'b0, 1'b1, 1'b0, 8'd0,  4'b0011, 3'd2};
    tbl[16] = '{1'b1, 8'd11, 1'b0, 1'b1, 1'b0, 8'd0,  4'b0111, 3'd3};
    tbl[17] = '{1'b1, 8'd12, 1'b0, 1'b0, 1'b1, 8'd8,  4'b1111, 3'd4};
    tbl[18] = '{1'b1, 8'd12, 1'b0, 1'b0, 1'b1, 8'd8,  4'b1111, 3'd4};
    tbl[19] = '{1'b1, 8'd12, 1'b1, 1'b1, 1'b1, 8'd8,  4'b1111, 3'd4};
    tbl[20] = '{1'b0, 8'd0,  1'b1, 1'b1, 1'b1, 8'd9,  4'b1111, 3'd4};
    tbl[21] = '{1'b0, 8'd0,  1'b1, 1'b1, 1'b1, 8'd10, 4'b1110, 3'd3};
    tbl[22] = '{1'b0, 8'd0,  1'b1, 1'b1, 1'b1, 8'd11, 4'b1100, 3'd2};
    tbl[23] = '{1'b0, 8'd0,  1'b1, 1'b1, 1'b1, 8'd12, 4'b1000, 3'd1};
    tbl[24] = '{1'b0, 8'd0,  1'b1, 1'b1, 1'b0, 8'd0,  4'b0000, 3'd0};

    resetn = 1'b0; in_valid = 1'b1; in_data = pay(8'hEE); in_dest = 5'd3; in_wen = 1'b1;
    ready_go = '1; kill = '0; stage_val = '0; stage_val_ok = '0; out_allow = 1'b1;
    src1 = '0; src2 = '0; src_re = '0;

    // reset state holds even across clock edges with input offered
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sv", stage_valid, 4'b0000);
    chk("rst_occ", occ, 3'd0);
    chk("rst_in_allow", in_allow, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_hit", fwd_hit, 2'b00);
    chk("rst_haz", hazard_stall, 1'b0);
    chk("rst_data", stage_data[63:0], 64'h0);
    @(negedge clk);
    resetn = 1'b1; in_valid = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      in_valid = tbl[i].iv; in_data = pay(tbl[i].tag); in_dest = 5'(i); in_wen = 1'b0;
      out_allow = tbl[i].oa;
      #1;
      chk($sformatf("v%0d_in_allow", i), in_allow, tbl[i].e_ia);
      chk($sformatf("v%0d_out_valid", i), out_valid, tbl[i].e_ov);
      if (tbl[i].e_ov)
        chk($sformatf("v%0d_out_data", i), out_data, pay(tbl[i].e_tag));
      chk($sformatf("v%0d_stage_valid", i), stage_valid, tbl[i].e_sv);
      chk($sformatf("v%0d_occ", i), occ, tbl[i].e_occ);
      chk($sformatf("v%0d_hit", i), fwd_hit, 2'b00);
    end

    // fill: stage3=A(d5) stage2=B(d0) stage1=C(d5) stage0=D(d7), then freeze
    out_allow = 1'b1;
    push(8'h20, 5'd5, 1'b1);
    push(8'h21, 5'd0, 1'b1);
    push(8'h22, 5'd5, 1'b1);
    push(8'h23, 5'd7, 1'b1);
    @(negedge clk);
    in_valid = 1'b0; out_allow = 1'b0;
    stage_val = {32'h0000_DEAD, 32'h0000_9999, 32'h0000_1234, 32'h0000_7777};
    #1;
    chk("full_sv", stage_valid, 4'b1111);
    chk("full_occ", occ, 3'd4);
    chk("full_in_allow", in_allow, 1'b0);
    chk("full_s1_data", stage_data[127:64], pay(8'h22));

    fwd_chk("f_youngest", 5'd5, 5'd0, 2'b01, 4'b1111, 4'b0000, 2'b01, 32'h1234, 32'h0, 1'b0);
    fwd_chk("f_disabled", 5'd5, 5'd7, 2'b00, 4'b1111, 4'b0000, 2'b00, 32'h0, 32'h0, 1'b0);
    fwd_chk("f_killskip", 5'd5, 5'd0, 2'b01, 4'b1111, 4'b0010, 2'b01, 32'hDEAD, 32'h0, 1'b0);
    fwd_chk("f_loaduse", 5'd0, 5'd7, 2'b10, 4'b1110, 4'b0000, 2'b00, 32'h0, 32'h0, 1'b1);
    fwd_chk("f_src2hit", 5'd0, 5'd7, 2'b10, 4'b1111, 4'b0000, 2'b10, 32'h0, 32'h7777, 1'b0);
    fwd_chk("f_zero", 5'd0, 5'd0, 2'b11, 4'b1111, 4'b0000, 2'b00, 32'h0, 32'h0, 1'b0);
    fwd_chk("f_both", 5'd5, 5'd7, 2'b11, 4'b1110, 4'b0000, 2'b01, 32'h1234, 32'h0, 1'b1);
    fwd_chk("f_miss", 5'd9, 5'd3, 2'b11, 4'b1111, 4'b0000, 2'b00, 32'h0, 32'h0, 1'b0);
    src_re = '0;

    // kill the two youngest while the pipe is blocked
    @(negedge clk);
    kill = 4'b0011;
    #1;
    chk("k_pre_out_valid", out_valid, 1'b1);
    @(negedge clk);
    kill = '0;
    #1;
    chk("k_sv", stage_valid, 4'b1100);
    chk("k_occ", occ, 3'd2);
    chk("k_out0", out_data, pay(8'h20));
    out_allow = 1'b1;
    @(negedge clk);
    #1;
    chk("k_sv1", stage_valid, 4'b1000);
    chk("k_out1_valid", out_valid, 1'b1);
    chk("k_out1", out_data, pay(8'h21));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("k_drained%0d", i), out_valid, 1'b0);
      chk($sformatf("k_sv_empty%0d", i), stage_valid, 4'b0000);
    end

    // asynchronous reset mid-stream, between clock edges
    push(8'h30, 5'd1, 1'b1);
    push(8'h31, 5'd2, 1'b1);
    push(8'h32, 5'd3, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("ar_pre_sv", stage_valid, 4'b0111);
    #1;
    resetn = 1'b0;
    #1;
    chk("ar_sv", stage_valid, 4'b0000);
    chk("ar_occ", occ, 3'd0);
    chk("ar_in_allow", in_allow, 1'b1);
    chk("ar_out_valid", out_valid, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    in_valid = 1'b1; in_data = pay(8'h40); in_dest = 5'd4; in_wen = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("ar_first_sv", stage_valid, 4'b0001);
    chk("ar_first_occ", occ, 3'd1);
    chk("ar_first_data", stage_data[63:0], pay(8'h40));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
